// File: rtl/fft_stage_sequencer.sv
// Stage sequencer for the in-place radix-2 FFT engine: trigger, issue and drain per stage.
// Optional FFT_SEQ_PERF_CNT_EN adds a saturating busy-cycle counter on o_cycle_count.
module fft_stage_sequencer #(
  parameter int unsigned MAX_INFLIGHT = 16
) (
  input  logic        clk,
  input  logic        i_resetn,
  input  logic        i_start,
  input  logic [2:0]  i_point_configuration,
  input  logic        i_hold,
  input  logic        i_abort,
  input  logic        i_dp_valid,
  output logic        o_working,
  output logic [2:0]  o_point_configuration,
  output logic        o_new_stage_trigger,
  output logic        o_issue_valid,
  output logic [2:0]  o_stage_idx,
  output logic        o_busy,
  output logic        o_done,
`ifdef FFT_SEQ_PERF_CNT_EN
  output logic        o_err,
  output logic [15:0] o_cycle_count
`else
  output logic        o_err
`endif
);

  typedef enum logic [2:0] {IDLE, TRIG, ISSUE, DRAIN, DONE} state_t;

  localparam logic [7:0] MAX_Q = 8'(MAX_INFLIGHT);

  state_t     state;
  logic [7:0] inflight;
  logic [7:0] bfly_cnt;
  logic [7:0] inflight_nxt;
  logic       spurious;
  logic       retire;
  logic       room;
  logic       last_stage;
  logic       start_ok;

  // Issue permission for next cycle looks at the post-edge inflight count so
  // the registered o_issue_valid can never push inflight past MAX_INFLIGHT.
  always_comb begin
    spurious     = i_dp_valid && (inflight == '0) && !o_issue_valid;
    retire       = i_dp_valid && !spurious;
    inflight_nxt = inflight;
    if (o_issue_valid && !retire)
      inflight_nxt = inflight + 8'd1;
    else if (!o_issue_valid && retire)
      inflight_nxt = inflight - 8'd1;
    room       = !i_hold && (inflight_nxt < MAX_Q);
    last_stage = (o_stage_idx == o_point_configuration + 3'd2);
    start_ok   = (state == IDLE) && i_start && (i_point_configuration <= 3'd5);
  end

  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state                 <= IDLE;
      inflight              <= '0;
      bfly_cnt              <= '0;
      o_working             <= 1'b0;
      o_point_configuration <= '0;
      o_new_stage_trigger   <= 1'b0;
      o_issue_valid         <= 1'b0;
      o_stage_idx           <= '0;
      o_busy                <= 1'b0;
      o_done                <= 1'b0;
      o_err                 <= 1'b0;
    end else begin
      o_new_stage_trigger <= 1'b0;
      o_issue_valid       <= 1'b0;
      o_done              <= 1'b0;
      o_err               <= spurious;
      inflight            <= inflight_nxt;

      if (i_abort && (state != IDLE)) begin
        state       <= IDLE;
        inflight    <= '0;
        bfly_cnt    <= '0;
        o_stage_idx <= '0;
        o_working   <= 1'b0;
        o_busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_ok) begin
              o_point_configuration <= i_point_configuration;
              o_stage_idx           <= '0;
              o_new_stage_trigger   <= 1'b1;
              o_working             <= 1'b1;
              o_busy                <= 1'b1;
              state                 <= TRIG;
            end else if (i_start) begin
              o_err <= 1'b1;
            end
          end
          TRIG: begin
            bfly_cnt      <= 8'd4 << o_point_configuration;
            o_issue_valid <= room;
            state         <= ISSUE;
          end
          ISSUE: begin
            if (o_issue_valid)
              bfly_cnt <= bfly_cnt - 8'd1;
            if (o_issue_valid && (bfly_cnt == 8'd1))
              state <= DRAIN;
            else
              o_issue_valid <= room;
          end
          DRAIN: begin
            if (inflight_nxt == '0) begin
              if (last_stage) begin
                o_working <= 1'b0;
                o_done    <= 1'b1;
                state     <= DONE;
              end else begin
                o_stage_idx         <= o_stage_idx + 3'd1;
                o_new_stage_trigger <= 1'b1;
                state               <= TRIG;
              end
            end
          end
          DONE: begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef FFT_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn)
      o_cycle_count <= '0;
    else if (start_ok)
      o_cycle_count <= '0;
    else if ((state != IDLE) && (o_cycle_count != '1))
      o_cycle_count <= o_cycle_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: two instances (MAX_INFLIGHT 16 and 2) driven in parallel,
// each fed by a fixed-latency datapath model.
module tb_fft_stage_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] code = '0;
  logic [3:0] lat = 4'd3;

  logic       working [2];
  logic       trig    [2];
  logic       issue   [2];
  logic       busy    [2];
  logic       done    [2];
  logic       err     [2];
  logic [2:0] pcfg    [2];
  logic [2:0] sidx    [2];
  logic       dpv     [2];
  logic       inj     [2];
  logic [15:0] pipe   [2];
`ifdef FFT_SEQ_PERF_CNT_EN
  logic [15:0] ccnt   [2];
`endif

  int n_checks = 0;
  int n_fail = 0;

  int n_trig [2], n_issue [2], n_done [2], n_err [2], n_busy [2];
  int infl [2], max_infl [2];
  int st_issue [2][8];
  int st_seq [2][8];

  always #5 clk = ~clk;

  fft_stage_sequencer #(.MAX_INFLIGHT(16)) dut (
    .clk(clk), .i_resetn(rst_n), .i_start(start), .i_point_configuration(code),
    .i_hold(hold), .i_abort(abort), .i_dp_valid(dpv[0]),
    .o_working(working[0]), .o_point_configuration(pcfg[0]),
    .o_new_stage_trigger(trig[0]), .o_issue_valid(issue[0]), .o_stage_idx(sidx[0]),
    .o_busy(busy[0]), .o_done(done[0]),
`ifdef FFT_SEQ_PERF_CNT_EN
    .o_err(err[0]), .o_cycle_count(ccnt[0])
`else
    .o_err(err[0])
`endif
  );

  fft_stage_sequencer #(.MAX_INFLIGHT(2)) dut2 (
    .clk(clk), .i_resetn(rst_n), .i_start(start), .i_point_configuration(code),
    .i_hold(hold), .i_abort(abort), .i_dp_valid(dpv[1]),
    .o_working(working[1]), .o_point_configuration(pcfg[1]),
    .o_new_stage_trigger(trig[1]), .o_issue_valid(issue[1]), .o_stage_idx(sidx[1]),
    .o_busy(busy[1]), .o_done(done[1]),
`ifdef FFT_SEQ_PERF_CNT_EN
    .o_err(err[1]), .o_cycle_count(ccnt[1])
`else
    .o_err(err[1])
`endif
  );

  // Datapath model: a retire appears exactly lat cycles after each issue; abort flushes it.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n)
        pipe[i] <= '0;
      else
        pipe[i] <= abort ? 16'd0 : {pipe[i][14:0], issue[i]};
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++)
      dpv[i] = pipe[i][lat - 4'd1] | inj[i];
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n || abort)
        infl[i] <= 0;
      else
        infl[i] <= infl[i] + int'(issue[i]) - int'(dpv[i] && !(infl[i] == 0 && !issue[i]));

      if (!rst_n || (start && !busy[i])) begin
        n_trig[i]   <= 0;
        n_issue[i]  <= 0;
        n_done[i]   <= 0;
        n_err[i]    <= 0;
        n_busy[i]   <= 0;
        max_infl[i] <= 0;
        for (int s = 0; s < 8; s++) begin
          st_issue[i][s] <= 0;
          st_seq[i][s]   <= 0;
        end
      end else begin
        if (trig[i]) begin
          if (n_trig[i] < 8) st_seq[i][n_trig[i]] <= int'(sidx[i]);
          n_trig[i] <= n_trig[i] + 1;
        end
        if (issue[i]) begin
          n_issue[i] <= n_issue[i] + 1;
          st_issue[i][sidx[i]] <= st_issue[i][sidx[i]] + 1;
        end
        if (done[i]) n_done[i] <= n_done[i] + 1;
        if (err[i])  n_err[i]  <= n_err[i] + 1;
        if (busy[i]) n_busy[i] <= n_busy[i] + 1;
        if (infl[i] > max_infl[i]) max_infl[i] <= infl[i];
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [2:0] c);
    cyc();
    code  = c;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy[0] || busy[1]) && n < budget) begin
      cyc();
      n++;
    end
    check("idle_timeout", int'(busy[0] || busy[1]), 0);
  endtask

  task automatic check_normal_code0(input string tag);
    check({tag, "_issues"}, n_issue[0], 12);
    check({tag, "_trigs"}, n_trig[0], 3);
    check({tag, "_done"}, n_done[0], 1);
    check({tag, "_busy_cycles"}, n_busy[0], 25);
    check({tag, "_err"}, n_err[0], 0);
  endtask

  initial begin
    int n;
    int held;
    inj[0] = 1'b0;
    inj[1] = 1'b0;

    // Reset state
    #12;
    check("rst_busy", int'(busy[0]), 0);
    check("rst_working", int'(working[0]), 0);
    check("rst_issue", int'(issue[0]), 0);
    check("rst_trig", int'(trig[0]), 0);
    check("rst_done", int'(done[0]), 0);
    check("rst_err", int'(err[0]), 0);
    check("rst_pcfg", int'(pcfg[0]), 0);
    check("rst_sidx", int'(sidx[0]), 0);
    #11 rst_n = 1'b1;

    // Code 0, latency 3: start-to-trigger and trigger-to-issue latency, then full run
    lat = 4'd3;
    do_start(3'd0);
    check("t1_trig_k1", int'(trig[0]), 1);
    check("t1_issue_k1", int'(issue[0]), 0);
    check("t1_working_k1", int'(working[0]), 1);
    check("t1_busy_k1", int'(busy[0]), 1);
    cyc();
    check("t1_trig_k2", int'(trig[0]), 0);
    check("t1_issue_k2", int'(issue[0]), 1);
    wait_idle(200);
    check_normal_code0("t1");
    for (int s = 0; s < 3; s++) begin
      check($sformatf("t1_stage%0d_issues", s), st_issue[0][s], 4);
      check($sformatf("t1_seq%0d", s), st_seq[0][s], s);
    end
    check("t1_working_end", int'(working[0]), 0);
`ifdef FFT_SEQ_PERF_CNT_EN
    check("t1_cycle_count", int'(ccnt[0]), 25);
    cyc();
    check("t1_cycle_count_hold", int'(ccnt[0]), 25);
`endif

    // Code 5, latency 6: MAX_INFLIGHT=2 instance throttles, default instance does not
    lat = 4'd6;
    do_start(3'd5);
    wait_idle(10000);
    check("t2_max_infl_m2", max_infl[1], 2);
    check("t2_issues_m2", n_issue[1], 1024);
    check("t2_trigs_m2", n_trig[1], 8);
    check("t2_stage0_m2", st_issue[1][0], 128);
    check("t2_stage7_m2", st_issue[1][7], 128);
    check("t2_seq7_m2", st_seq[1][7], 7);
    check("t2_done_m2", n_done[1], 1);
    check("t2_max_infl_m16", max_infl[0], 6);
    check("t2_busy_cycles_m16", n_busy[0], 8 * (1 + 128 + 6) + 1);
    check("t2_pcfg", int'(pcfg[0]), 5);

    // Illegal code 6
    do_start(3'd6);
    check("t3_err", int'(err[0]), 1);
    check("t3_busy", int'(busy[0]), 0);
    check("t3_trig", int'(trig[0]), 0);
    check("t3_pcfg_kept", int'(pcfg[0]), 5);
    cyc();
    check("t3_err_end", int'(err[0]), 0);

    // Code 1, latency 3, hold for 5 cycles starting at the stage-2 trigger
    lat = 4'd3;
    do_start(3'd1);
    n = 0;
    while (!(trig[0] && sidx[0] == 3'd2) && n < 100) begin
      cyc();
      n++;
    end
    check("t4_stage2_seen", int'(trig[0] && sidx[0] == 3'd2), 1);
    hold = 1'b1;
    held = 0;
    repeat (5) begin
      cyc();
      held += int'(issue[0]);
    end
    hold = 1'b0;
    check("t4_hold_noissue", held, 0);
    wait_idle(500);
    check("t4_stage2_issues", st_issue[0][2], 8);
    check("t4_issues", n_issue[0], 32);
    check("t4_trigs", n_trig[0], 4);
    check("t4_busy_cycles", n_busy[0], 4 * (1 + 8 + 3) + 1 + 5);

    // Abort during DRAIN of stage 1, then a clean code-0 run
    do_start(3'd0);
    n = 0;
    while (!(trig[0] && sidx[0] == 3'd1) && n < 100) begin
      cyc();
      n++;
    end
    repeat (5) cyc();
    check("t5_in_drain", int'(working[0] && !issue[0] && sidx[0] == 3'd1), 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("t5_busy", int'(busy[0]), 0);
    check("t5_working", int'(working[0]), 0);
    check("t5_sidx", int'(sidx[0]), 0);
    repeat (10) cyc();
    check("t5_no_done", n_done[0], 0);
    check("t5_no_err", n_err[0], 0);
    do_start(3'd0);
    wait_idle(200);
    check_normal_code0("t5_rerun");

    // Spurious retire in IDLE, then a run proving inflight did not underflow
    cyc();
    inj[0] = 1'b1;
    cyc();
    inj[0] = 1'b0;
    check("t6_spurious_err", int'(err[0]), 1);
    cyc();
    check("t6_spurious_err_end", int'(err[0]), 0);
    do_start(3'd0);
    wait_idle(200);
    check_normal_code0("t6_after");

    // Asynchronous reset mid-ISSUE
    do_start(3'd1);
    repeat (3) cyc();
    check("t7_issuing", int'(issue[0]), 1);
    #3 rst_n = 1'b0;
    #1;
    check("t7_busy", int'(busy[0]), 0);
    check("t7_working", int'(working[0]), 0);
    check("t7_issue", int'(issue[0]), 0);
    check("t7_pcfg", int'(pcfg[0]), 0);
    check("t7_sidx", int'(sidx[0]), 0);
    check("t7_err", int'(err[0]), 0);
`ifdef FFT_SEQ_PERF_CNT_EN
    check("t7_cycle_count", int'(ccnt[0]), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    do_start(3'd0);
    wait_idle(200);
    check_normal_code0("t7_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
